sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Serial-in, parallel-out deserializer that directly feeds the 4-bit parallel-load register stage.
- Accepts one bit per cycle over a valid/ready handshake and assembles WIDTH-bit words.
- Presents each word on a held parallel output with its own valid/ready handshake.
- One skid word of buffering absorbs downstream backpressure without dropping bits.

Parameters:
- WIDTH, 4: word width in bits; legal range 2..32.
- MSB_FIRST, 1: bit order. 1 = first received bit lands in pout[WIDTH-1]; 0 = first received bit lands in pout[0].
- CNT_W, 8: width of the frame counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- sin  in  1  serial data bit
- sin_valid  in  1  sin carries a bit this cycle
- sin_ready  out  1  bit accepted on an edge where sin_valid && sin_ready
- clr  in  1  synchronous flush of the partially assembled word
- pout  out  WIDTH  assembled parallel word
- pout_valid  out  1  pout holds a complete word
- pout_ready  in  1  consumer takes pout on an edge where pout_valid && pout_ready
- bit_cnt  out  clog2(WIDTH)  bits collected in the current partial word
- frame_cnt  out  CNT_W  words delivered to pout_valid since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset: on a clk edge with rst=1, sreg, pout, bit_cnt and frame_cnt clear to 0; pout_valid=0; the skid flag sfull=0.
- sin_ready is combinational: !sfull && !clr && !rst.
- Priority: rst > clr > normal operation.
- Accept (sin_valid && sin_ready):
  - MSB_FIRST=1 shifts sreg <= {sreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0 shifts sreg <= {sin, sreg[WIDTH-1:1]}.
  - If bit_cnt < WIDTH-1, bit_cnt increments.
- Word completion (accept with bit_cnt == WIDTH-1): bit_cnt <= 0. The completed word includes the bit just accepted.
  - If the hold register is free (!pout_valid, or pout_valid && pout_ready this cycle): pout <= completed word, pout_valid <= 1, frame_cnt increments. Latency is one edge after the last bit is accepted.
  - Otherwise: the completed word stays in sreg and sfull <= 1. sin_ready drops next cycle (backpressure).
- Skid drain (sfull && pout_ready): pout <= sreg, sfull <= 0, pout_valid stays 1, frame_cnt increments. sin_ready reasserts next cycle.
- Hold drain (pout_valid && pout_ready with nothing to load): pout_valid <= 0; pout keeps its last value.
- Throughput: with pout_ready held high, sustained 1 bit/cycle and 1 word per WIDTH cycles with no bubbles.
- clr:
  - bit_cnt <= 0 and the partial sreg contents are discarded; sreg is zeroed only when sfull=0.
  - A word parked in sreg (sfull=1) and the word in the hold register are retained.
  - No bit is accepted in a clr cycle.
- Simultaneous events:
  - Completion in the same cycle the hold register drains loads the new word directly, so pout_valid stays high.
  - sfull=1 and a sin_valid bit in the same cycle: the bit is not accepted (sin_ready=0).
- Reset mid-word or mid-backpressure discards all buffered data, including the parked and held words.
- pout is stable while pout_valid && !pout_ready.

Decomposition:
- Shared package sipo_pkg holds the bit-order constants (BIT_ORDER_MSB=1, BIT_ORDER_LSB=0) and the function computing the bit_cnt width from WIDTH.
- One natural sub-module, sipo_shift_stage, holds sreg, bit_cnt, the shift direction and the word_done pulse.
- The top level holds the hold register, sfull, frame_cnt and the handshake logic.

Test Plan:
- Basic MSB-first (WIDTH=4, pout_ready=1): send 1,0,0,1 on consecutive cycles → pout=4'b1001 and pout_valid=1 one edge after the 4th bit; frame_cnt=1.
- Streaming: send 1011 then 1111 back-to-back with pout_ready=1 → pout=1011 then exactly 4 cycles later 1111; sin_ready never deasserts; frame_cnt=2.
- Backpressure: pout_ready=0, send 1011 then 1111 → pout holds 1011 and sin_ready=0 after the 8th bit. Pulse pout_ready for 1 cycle → pout=1111 next edge, pout_valid stays 1, sin_ready=1 again.
- clr mid-word: send 1,1, assert clr, then send 0,1,1,0 → pout=4'b0110 and bit_cnt=0 after the clr edge. With a parked word present, clr leaves sfull=1 and that word intact.
- LSB-first (MSB_FIRST=0): send 1,0,0,0 → pout=4'b0001.
- Reset mid-operation: assert rst after 2 bits with a word held → next edge pout_valid=0, pout=0, bit_cnt=0, frame_cnt=0. sin_ready=0 during rst and 1 on the first cycle after.

Source files
------------

// File: rtl/sipo_deserializer_pkg.sv
// Shared constants and helpers for the serial-in, parallel-out deserializer.
package sipo_pkg;

    localparam int BIT_ORDER_LSB = 0;
    localparam int BIT_ORDER_MSB = 1;

    // Width of the in-word bit counter; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input and parallel output handshakes of the deserializer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;

    modport master (
        output sin, sin_valid, pout_ready,
        input  sin_ready, pout, pout_valid
    );

    modport slave (
        input  sin, sin_valid, pout_ready,
        output sin_ready, pout, pout_valid
    );
endinterface

// File: rtl/sipo_deserializer_shift_stage.sv
// Shift register and in-word bit counter; flags the accept that completes a word.
module sipo_shift_stage
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = BIT_ORDER_MSB,
    localparam int BC_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             accept,
    input  logic             sin,
    input  logic             sfull,
    output logic [WIDTH-1:0] sreg,
    output logic [BC_W-1:0]  bit_cnt,
    output logic             word_done,
    output logic [WIDTH-1:0] word
);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_reg;
    logic [BC_W-1:0]  cnt_reg;
    logic [WIDTH-1:0] shifted;

    generate
        if (MSB_FIRST == BIT_ORDER_MSB) begin : g_msb_first
            assign shifted = {sreg_reg[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign shifted = {sin, sreg_reg[WIDTH-1:1]};
        end
    endgenerate

    // The completed word includes the bit being accepted this cycle.
    assign word_done = accept && (cnt_reg == LAST_BIT);
    assign word      = shifted;
    assign sreg      = sreg_reg;
    assign bit_cnt   = cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_reg <= '0;
            cnt_reg  <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
            // A parked word lives in sreg and must survive a flush.
            if (!sfull) begin
                sreg_reg <= '0;
            end
        end else if (accept) begin
            sreg_reg <= shifted;
            cnt_reg  <= (cnt_reg == LAST_BIT) ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Deserializer top: hold register, one-word skid (parked in sreg) and frame counter.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = BIT_ORDER_MSB,
    parameter int CNT_W     = 8,
    localparam int BC_W     = cnt_width(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    sipo_deserializer_if.slave    bus,
    output logic [BC_W-1:0]       bit_cnt,
    output logic [CNT_W-1:0]      frame_cnt
);
    logic [WIDTH-1:0] pout_reg;
    logic             pout_valid_reg;
    logic             sfull_reg;
    logic [CNT_W-1:0] frame_cnt_reg;

    logic             sin_ready_int;
    logic             accept;
    logic             hold_free;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] sreg;

    assign sin_ready_int = !sfull_reg && !clr && !rst;
    assign accept        = bus.sin_valid && sin_ready_int;
    assign hold_free     = !pout_valid_reg || bus.pout_ready;

    sipo_shift_stage #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .accept    (accept),
        .sin       (bus.sin),
        .sfull     (sfull_reg),
        .sreg      (sreg),
        .bit_cnt   (bit_cnt),
        .word_done (word_done),
        .word      (word)
    );

    // word_done needs an accept, which sfull blocks, so completion and skid drain never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            pout_reg       <= '0;
            pout_valid_reg <= 1'b0;
            sfull_reg      <= 1'b0;
            frame_cnt_reg  <= '0;
        end else if (word_done) begin
            if (hold_free) begin
                pout_reg       <= word;
                pout_valid_reg <= 1'b1;
                frame_cnt_reg  <= frame_cnt_reg + 1'b1;
            end else begin
                sfull_reg <= 1'b1;
            end
        end else if (sfull_reg && bus.pout_ready) begin
            pout_reg      <= sreg;
            sfull_reg     <= 1'b0;
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end else if (pout_valid_reg && bus.pout_ready) begin
            pout_valid_reg <= 1'b0;
        end
    end

    assign bus.sin_ready  = sin_ready_int;
    assign bus.pout       = pout_reg;
    assign bus.pout_valid = pout_valid_reg;
    assign frame_cnt      = frame_cnt_reg;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: MSB-first and LSB-first instances, word scoreboard.
module tb_sipo_deserializer;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_m = 1'b0;
    logic       clr_l = 1'b0;
    logic [1:0] bc_m, bc_l;
    logic [7:0] fc_m, fc_l;

    sipo_deserializer_if #(.WIDTH(W)) m_if ();
    sipo_deserializer_if #(.WIDTH(W)) l_if ();

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1), .CNT_W(8)) dut_m (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_m),
        .bus       (m_if.slave),
        .bit_cnt   (bc_m),
        .frame_cnt (fc_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0), .CNT_W(8)) dut_l (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_l),
        .bus       (l_if.slave),
        .bit_cnt   (bc_l),
        .frame_cnt (fc_l)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] q_m[$];
    logic [W-1:0] q_l[$];
    logic [W-1:0] mdl_m = '0;
    logic [W-1:0] mdl_l = '0;
    int           cnt_m = 0;
    int           cnt_l = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_m(input logic b);
        chk("m_sin_ready", 32'(m_if.sin_ready), 1);
        m_if.sin       = b;
        m_if.sin_valid = 1'b1;
        mdl_m = {mdl_m[W-2:0], b};
        cnt_m++;
        if (cnt_m == W) begin
            q_m.push_back(mdl_m);
            cnt_m = 0;
        end
        cyc();
        m_if.sin_valid = 1'b0;
    endtask

    task automatic send_l(input logic b);
        chk("l_sin_ready", 32'(l_if.sin_ready), 1);
        l_if.sin       = b;
        l_if.sin_valid = 1'b1;
        mdl_l = {b, mdl_l[W-1:1]};
        cnt_l++;
        if (cnt_l == W) begin
            q_l.push_back(mdl_l);
            cnt_l = 0;
        end
        cyc();
        l_if.sin_valid = 1'b0;
    endtask

    // Scoreboard: every word taken by the consumer must match the next queued word.
    always @(negedge clk) begin
        if (!rst && m_if.pout_valid && m_if.pout_ready) begin
            if (q_m.size() == 0) chk("m_extra_word", 32'(q_m.size()), 1);
            else                 chk("m_word", 32'(m_if.pout), 32'(q_m.pop_front()));
            $display("m word taken: %b (frame_cnt %0d)", m_if.pout, fc_m);
        end
        if (!rst && l_if.pout_valid && l_if.pout_ready) begin
            if (q_l.size() == 0) chk("l_extra_word", 32'(q_l.size()), 1);
            else                 chk("l_word", 32'(l_if.pout), 32'(q_l.pop_front()));
            $display("l word taken: %b (frame_cnt %0d)", l_if.pout, fc_l);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_if.sin = 1'b0; m_if.sin_valid = 1'b0; m_if.pout_ready = 1'b1;
        l_if.sin = 1'b0; l_if.sin_valid = 1'b0; l_if.pout_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_sin_ready", 32'(m_if.sin_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_sin_ready", 32'(m_if.sin_ready), 1);
        chk("rst_pout", 32'(m_if.pout), 0);
        chk("rst_pout_valid", 32'(m_if.pout_valid), 0);
        chk("rst_bit_cnt", 32'(bc_m), 0);
        chk("rst_frame_cnt", 32'(fc_m), 0);

        // Basic MSB-first word.
        send_m(1); send_m(0); send_m(0); send_m(1);
        chk("basic_pout", 32'(m_if.pout), 'b1001);
        chk("basic_valid", 32'(m_if.pout_valid), 1);
        chk("basic_frame", 32'(fc_m), 1);
        chk("basic_bit_cnt", 32'(bc_m), 0);
        cyc();
        chk("basic_drained", 32'(m_if.pout_valid), 0);
        chk("basic_pout_kept", 32'(m_if.pout), 'b1001);

        // Back-to-back streaming.
        send_m(1); send_m(0); send_m(1); send_m(1);
        chk("stream_pout1", 32'(m_if.pout), 'b1011);
        chk("stream_frame1", 32'(fc_m), 2);
        send_m(1); send_m(1); send_m(1);
        chk("stream_mid_pout", 32'(m_if.pout), 'b1011);
        chk("stream_mid_valid", 32'(m_if.pout_valid), 0);
        send_m(1);
        chk("stream_pout2", 32'(m_if.pout), 'b1111);
        chk("stream_frame2", 32'(fc_m), 3);
        cyc();

        // Backpressure: second word parks in the skid.
        m_if.pout_ready = 1'b0;
        send_m(1); send_m(0); send_m(1); send_m(1);
        chk("bp_pout1", 32'(m_if.pout), 'b1011);
        chk("bp_frame1", 32'(fc_m), 4);
        send_m(1); send_m(1); send_m(1); send_m(1);
        chk("bp_sin_ready", 32'(m_if.sin_ready), 0);
        chk("bp_pout_held", 32'(m_if.pout), 'b1011);
        chk("bp_valid_held", 32'(m_if.pout_valid), 1);
        chk("bp_frame_held", 32'(fc_m), 4);
        m_if.sin = 1'b0; m_if.sin_valid = 1'b1;
        cyc();
        m_if.sin_valid = 1'b0;
        chk("bp_bit_blocked", 32'(bc_m), 0);
        clr_m = 1'b1;
        cyc();
        clr_m = 1'b0;
        #1;
        chk("clr_keeps_sfull", 32'(m_if.sin_ready), 0);
        chk("clr_keeps_hold", 32'(m_if.pout), 'b1011);
        m_if.pout_ready = 1'b1;
        cyc();
        m_if.pout_ready = 1'b0;
        chk("skid_pout", 32'(m_if.pout), 'b1111);
        chk("skid_valid", 32'(m_if.pout_valid), 1);
        chk("skid_frame", 32'(fc_m), 5);
        chk("skid_sin_ready", 32'(m_if.sin_ready), 1);
        m_if.pout_ready = 1'b1;
        cyc();
        chk("skid_drained", 32'(m_if.pout_valid), 0);

        // clr mid-word discards the partial bits.
        send_m(1); send_m(1);
        clr_m = 1'b1;
        #1;
        chk("clr_sin_ready", 32'(m_if.sin_ready), 0);
        cnt_m = 0;
        cyc();
        clr_m = 1'b0;
        #1;
        chk("clr_bit_cnt", 32'(bc_m), 0);
        send_m(0); send_m(1); send_m(1); send_m(0);
        chk("clr_pout", 32'(m_if.pout), 'b0110);
        chk("clr_frame", 32'(fc_m), 6);
        cyc();

        // Reset with a held word and a partial word.
        m_if.pout_ready = 1'b0;
        send_m(1); send_m(0); send_m(1); send_m(0);
        chk("pre_rst_pout", 32'(m_if.pout), 'b1010);
        chk("pre_rst_frame", 32'(fc_m), 7);
        send_m(1); send_m(1);
        chk("pre_rst_bit_cnt", 32'(bc_m), 2);
        rst = 1'b1;
        #1;
        chk("in_rst_sin_ready", 32'(m_if.sin_ready), 0);
        cyc();
        chk("mid_rst_valid", 32'(m_if.pout_valid), 0);
        chk("mid_rst_pout", 32'(m_if.pout), 0);
        chk("mid_rst_bit_cnt", 32'(bc_m), 0);
        chk("mid_rst_frame", 32'(fc_m), 0);
        q_m.delete();
        cnt_m = 0;
        rst = 1'b0;
        #1;
        chk("after_rst_sin_ready", 32'(m_if.sin_ready), 1);
        m_if.pout_ready = 1'b1;

        // LSB-first instance.
        send_l(1); send_l(0); send_l(0); send_l(0);
        chk("lsb_pout", 32'(l_if.pout), 'b0001);
        chk("lsb_valid", 32'(l_if.pout_valid), 1);
        chk("lsb_frame", 32'(fc_l), 1);
        cyc();

        chk("m_queue_drained", 32'(q_m.size()), 0);
        chk("l_queue_drained", 32'(q_l.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
